// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST camera front end.
//   MNIST_W / MNIST_H : native classifier image size
//   mnist_img_t       : packed binarized image, [row][col]
//   sampler_state_t   : frame sampler FSM states
package mnist_pkg;

  localparam int unsigned MNIST_W = 28;
  localparam int unsigned MNIST_H = 28;

  typedef logic [MNIST_H-1:0][MNIST_W-1:0] mnist_img_t;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } sampler_state_t;

endpackage

// File: rtl/mnist_col_accumulator.sv
// Per-column block accumulators for one band of SCALE x SCALE blocks.
//   clk      : pixel clock
//   reset_n  : synchronous, active-low reset
//   clear    : zero every accumulator (wins over add)
//   add_en   : add add_data into accumulator add_col
//   add_col  : target column (block index)
//   add_data : pixel value
//   row_bits : per-column threshold result, bit c = block c mean >= THRESHOLD
module mnist_col_accumulator #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned SCALE_LOG2 = 4,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned THRESHOLD  = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     add_en,
  input  logic [$clog2(IMG_W)-1:0] add_col,
  input  logic [DATA_WIDTH-1:0]    add_data,
  output logic [IMG_W-1:0]         row_bits
);

  localparam int unsigned ColW = $clog2(IMG_W);
  // A block holds 2^(2*SCALE_LOG2) pixels, so this width cannot overflow.
  localparam int unsigned AccW = DATA_WIDTH + 2 * SCALE_LOG2;
  // Compare the block sum against the threshold scaled by the pixel count; no divider.
  localparam logic [AccW-1:0] ThreshSum = AccW'(THRESHOLD << (2 * SCALE_LOG2));

  logic [AccW-1:0] acc_q [IMG_W];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < IMG_W; c++) acc_q[c] <= '0;
    end else if (clear) begin
      for (int c = 0; c < IMG_W; c++) acc_q[c] <= '0;
    end else if (add_en) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (add_col == ColW'(c)) acc_q[c] <= acc_q[c] + AccW'(add_data);
      end
    end
  end

  always_comb begin
    row_bits = '0;
    for (int c = 0; c < IMG_W; c++) row_bits[c] = (acc_q[c] >= ThreshSum);
  end

endmodule

// File: rtl/mnist_frame_sampler.sv
// OV2640 pixel stream -> binarized IMG_H x IMG_W image with valid/ready output.
//   clk           : pixel clock (ov2640_pixclk)
//   reset_n       : synchronous, active-low reset
//   s_vsync       : frame-active level
//   s_href        : line-active level
//   s_data        : pixel, qualified by s_vsync & s_href
//   m_data        : published image, bit [row*IMG_W+col]
//   m_valid       : m_data holds an unconsumed frame
//   m_ready       : consumer accepts m_data
//   m_frame_count : published frame count, wraps
//   overrun       : pulse, complete frame dropped because output was still held
//   frame_drop    : pulse, frame ended with fewer than IMG_H rows complete
module mnist_frame_sampler
  import mnist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned SCALE_LOG2 = 4,
  parameter int unsigned IMG_W      = MNIST_W,
  parameter int unsigned IMG_H      = MNIST_H,
  parameter int unsigned X_OFFSET   = 0,
  parameter int unsigned Y_OFFSET   = 0,
  parameter int unsigned THRESHOLD  = 512
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_vsync,
  input  logic                   s_href,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic [IMG_H*IMG_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [7:0]             m_frame_count,
  output logic                   overrun,
  output logic                   frame_drop
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H + 1);
  localparam int unsigned CntW = 16;
  localparam int unsigned WinW = IMG_W << SCALE_LOG2;
  localparam int unsigned WinH = IMG_H << SCALE_LOG2;

  sampler_state_t state_q, state_d;

  logic [CntW-1:0] x_q, x_d, y_q, y_d;
  logic [RowW-1:0] row_q, row_d, row_total;
  logic            line_q;

  logic [IMG_H-1:0][IMG_W-1:0] working_q, working_d, m_data_q, m_data_d;
  logic                        m_valid_q, m_valid_d;
  logic [7:0]                  count_q, count_d;
  logic                        overrun_q, overrun_d, drop_q, drop_d;

  logic            pix_valid, line_end, frame_end, frame_start;
  logic [CntW-1:0] dx, dy;
  logic            x_in, y_in, acc_add, commit, publish, full;
  logic [ColW-1:0] acc_col;
  logic [IMG_W-1:0] row_bits;

  always_comb begin
    pix_valid   = (state_q == ACTIVE) && s_vsync && s_href;
    // Qualified line ended; also fires when href and vsync drop together.
    line_end    = (state_q == ACTIVE) && line_q && !(s_vsync && s_href);
    frame_end   = (state_q == ACTIVE) && !s_vsync;
    frame_start = (state_q == IDLE) && s_vsync;

    dx   = x_q - CntW'(X_OFFSET);
    dy   = y_q - CntW'(Y_OFFSET);
    x_in = (x_q >= CntW'(X_OFFSET)) && (dx < CntW'(WinW));
    y_in = (y_q >= CntW'(Y_OFFSET)) && (dy < CntW'(WinH));

    acc_add = pix_valid && x_in && y_in;
    acc_col = dx[SCALE_LOG2 +: ColW];
    commit  = line_end && y_in && (&dy[SCALE_LOG2-1:0]) && (row_q < RowW'(IMG_H));
  end

  mnist_col_accumulator #(
    .DATA_WIDTH(DATA_WIDTH),
    .SCALE_LOG2(SCALE_LOG2),
    .IMG_W     (IMG_W),
    .THRESHOLD (THRESHOLD)
  ) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (frame_start || commit),
    .add_en  (acc_add),
    .add_col (acc_col),
    .add_data(s_data),
    .row_bits(row_bits)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    if (!s_vsync) state_d = IDLE;
      IDLE:    if (s_vsync) state_d = ACTIVE;
      ACTIVE:  if (!s_vsync) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    x_d = x_q;
    if (!s_href || frame_start) x_d = '0;
    else if (pix_valid)         x_d = x_q + CntW'(1);

    y_d = y_q;
    if (frame_start)   y_d = '0;
    else if (line_end) y_d = y_q + CntW'(1);

    row_total = row_q + RowW'(commit);
    row_d     = frame_start ? '0 : row_total;

    working_d = working_q;
    if (frame_start) working_d = '0;
    for (int r = 0; r < IMG_H; r++) begin
      if (commit && row_q == RowW'(r)) working_d[r] = row_bits;
    end
  end

  // A row committed in the frame-end cycle counts, so publish from working_d.
  always_comb begin
    full      = frame_end && (row_total == RowW'(IMG_H));
    publish   = full && (!m_valid_q || m_ready);
    overrun_d = full && m_valid_q && !m_ready;
    drop_d    = frame_end && (row_total != RowW'(IMG_H));
    m_valid_d = publish || (m_valid_q && !m_ready);
    m_data_d  = publish ? working_d : m_data_q;
    count_d   = publish ? count_q + 8'd1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= SYNC;
      x_q       <= '0;
      y_q       <= '0;
      row_q     <= '0;
      line_q    <= 1'b0;
      working_q <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      row_q     <= row_d;
      line_q    <= s_vsync && s_href;
      working_q <= working_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign m_frame_count = count_q;
  assign overrun       = overrun_q;
  assign frame_drop    = drop_q;

endmodule

// File: tb/tb_mnist_frame_sampler.sv
// Randomized self-checking bench for mnist_frame_sampler on a reduced geometry
// (4x4 blocks, 8x6 image, window offset (2,1)) so each frame is ~1.2k cycles.
module tb_mnist_frame_sampler;

  localparam int DW    = 10;
  localparam int SL    = 2;
  localparam int BLK   = 1 << SL;
  localparam int IW    = 8;
  localparam int IH    = 6;
  localparam int XO    = 2;
  localparam int YO    = 1;
  localparam int THR   = 512;
  localparam int NB    = IW * IH;
  localparam int CAM_W = XO + IW * BLK + 2;
  localparam int CAM_H = YO + IH * BLK + 1;

  logic          clk, reset_n, s_vsync, s_href, m_valid, m_ready, overrun, frame_drop;
  logic [DW-1:0] s_data;
  logic [NB-1:0] m_data;
  logic [7:0]    m_frame_count;

  mnist_frame_sampler #(
    .DATA_WIDTH(DW),
    .SCALE_LOG2(SL),
    .IMG_W     (IW),
    .IMG_H     (IH),
    .X_OFFSET  (XO),
    .Y_OFFSET  (YO),
    .THRESHOLD (THR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_vsync      (s_vsync),
    .s_href       (s_href),
    .s_data       (s_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_frame_count(m_frame_count),
    .overrun      (overrun),
    .frame_drop   (frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail, n_ovr, n_drop;
  logic [DW-1:0] px [CAM_H][CAM_W];
  logic          exp_valid;
  logic [NB-1:0] exp_data;
  logic [NB-1:0] all_ones;
  logic [NB-1:0] bit29;
  int            exp_count;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse counters and hold-stability check on the opposite clock edge.
  always @(negedge clk) begin
    if (overrun) n_ovr++;
    if (frame_drop) n_drop++;
    if (reset_n && exp_valid && !m_ready) check_eq("hold_data", m_data, exp_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: rows complete once all BLK lines of the band were sent.
  function automatic int model_rows(input int lines);
    int rows = 0;
    for (int r = 0; r < IH; r++) if (lines >= YO + (r + 1) * BLK) rows++;
    return rows;
  endfunction

  function automatic logic [NB-1:0] model_img(input int lines);
    logic [NB-1:0] img = '0;
    int sum;
    for (int r = 0; r < model_rows(lines); r++) begin
      for (int c = 0; c < IW; c++) begin
        sum = 0;
        for (int i = 0; i < BLK; i++)
          for (int j = 0; j < BLK; j++) sum += int'(px[YO + r * BLK + i][XO + c * BLK + j]);
        img[r * IW + c] = (sum >= THR * BLK * BLK);
      end
    end
    return img;
  endfunction

  task automatic fill_const(input int v);
    for (int l = 0; l < CAM_H; l++) for (int x = 0; x < CAM_W; x++) px[l][x] = DW'(v);
  endtask

  task automatic fill_rand();
    int base [IH][IW];
    int v;
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) base[r][c] = $urandom_range(400, 624);
    for (int l = 0; l < CAM_H; l++) begin
      for (int x = 0; x < CAM_W; x++) begin
        if (l >= YO && l < YO + IH * BLK && x >= XO && x < XO + IW * BLK) begin
          v = base[(l - YO) / BLK][(x - XO) / BLK] + $urandom_range(0, 64) - 32;
          px[l][x] = DW'(v);
        end else begin
          px[l][x] = DW'($urandom_range(0, 1023));
        end
      end
    end
  endtask

  // Block (row 3, col 5): 8 px of 1023 then 8 px of v2, everything else 0.
  task automatic fill_block(input int v2);
    fill_const(0);
    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++)
        px[YO + 3 * BLK + i][XO + 5 * BLK + j] = (i < 2) ? DW'(1023) : DW'(v2);
  endtask

  task automatic cyc(input logic vs, input logic hr, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    s_vsync = vs;
    s_href  = hr;
    s_data  = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, m_valid, 0);
    check_eq({tag, "_data"}, m_data, 0);
    check_eq({tag, "_count"}, m_frame_count, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_drop"}, frame_drop, 0);
  endtask

  // Sends one frame; returns just after driving the vsync fall.
  task automatic send_frame(input int lines, input bit simul, input int rst_line);
    repeat (4) cyc(1'b1, 1'b0, '0);
    for (int l = 0; l < lines; l++) begin
      for (int x = 0; x < CAM_W; x++) begin
        cyc(1'b1, 1'b1, px[l][x]);
        if (l == rst_line && x == CAM_W / 2) reset_n = 1'b0;
        if (l == rst_line && x == CAM_W / 2 + 2) begin
          exp_valid = 1'b0;
          exp_data  = '0;
          exp_count = 0;
          check_reset_outputs("midreset");
        end
        if (l == rst_line && x == CAM_W / 2 + 3) reset_n = 1'b1;
      end
      if (!(simul && l == lines - 1)) repeat (8) cyc(1'b1, 1'b0, '0);
    end
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic end_frame(input string tag, input int lines, input bit ignored);
    logic [NB-1:0] img;
    img = model_img(lines);
    @(posedge clk);
    #1;
    if (ignored) begin
      check_eq({tag, "_nodrop"}, frame_drop, 0);
    end else if (model_rows(lines) == IH) begin
      if (!exp_valid || m_ready) begin
        exp_valid = 1'b1;
        exp_data  = img;
        exp_count = (exp_count + 1) % 256;
      end else begin
        check_eq({tag, "_overrun"}, overrun, 1);
      end
    end else begin
      check_eq({tag, "_drop"}, frame_drop, 1);
    end
    check_eq({tag, "_valid"}, m_valid, exp_valid);
    if (exp_valid) check_eq({tag, "_data"}, m_data, exp_data);
    check_eq({tag, "_count"}, m_frame_count, exp_count);
    if (exp_valid && m_ready) begin
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      check_eq({tag, "_valid_drop"}, m_valid, 0);
    end
    repeat (6) cyc(1'b0, 1'b0, '0);
  endtask

  initial begin
    int ovr0, drop0;
    n_chk = 0; n_fail = 0; n_ovr = 0; n_drop = 0;
    reset_n = 1'b0; s_vsync = 1'b0; s_href = 1'b0; s_data = '0; m_ready = 1'b1;
    exp_valid = 1'b0; exp_data = '0; exp_count = 0;
    all_ones = '1;
    bit29 = '0;
    bit29[29] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, '0);

    // Full bright frame.
    fill_const(1023);
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t1", CAM_H, 1'b0);
    check_eq("t1_ones", m_data, all_ones);
    check_eq("t1_count", m_frame_count, 1);

    // Threshold boundary.
    fill_const(511);
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t2a", CAM_H, 1'b0);
    check_eq("t2_511", m_data, 0);
    fill_const(512);
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t2b", CAM_H, 1'b0);
    check_eq("t2_512", m_data, all_ones);

    // Single block at the sum boundary.
    fill_block(2);
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t3a", CAM_H, 1'b0);
    check_eq("t3_sum_above", m_data, bit29);
    fill_block(1);
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t3b", CAM_H, 1'b0);
    check_eq("t3_sum_equal", m_data, bit29);
    fill_block(0);
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t3c", CAM_H, 1'b0);
    check_eq("t3_sum_below", m_data, 0);

    // Random frames; the last one ends the final window line together with vsync.
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      send_frame(CAM_H, 1'b0, -1);
      end_frame("rand", CAM_H, 1'b0);
    end
    fill_rand();
    send_frame(YO + IH * BLK, 1'b1, -1);
    end_frame("simul", YO + IH * BLK, 1'b0);

    // Short frame is dropped.
    drop0 = n_drop;
    fill_rand();
    send_frame(20, 1'b0, -1);
    end_frame("t5", 20, 1'b0);
    check_eq("t5_drop_once", n_drop - drop0, 1);
    check_eq("t5_valid", m_valid, 0);

    // Back-pressure: second frame overruns, first held.
    ovr0 = n_ovr;
    m_ready = 1'b0;
    fill_rand();
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t4a", CAM_H, 1'b0);
    fill_rand();
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t4b", CAM_H, 1'b0);
    check_eq("t4_overrun_once", n_ovr - ovr0, 1);
    check_eq("t4_held_valid", m_valid, 1);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    check_eq("t4_release", m_valid, 0);
    repeat (4) cyc(1'b0, 1'b0, '0);

    // Reset mid-frame: remainder ignored, next frame publishes as the first.
    drop0 = n_drop;
    fill_const(1023);
    send_frame(CAM_H, 1'b0, 10);
    end_frame("t6a", CAM_H, 1'b1);
    check_eq("t6_no_drop", n_drop - drop0, 0);
    fill_rand();
    send_frame(CAM_H, 1'b0, -1);
    end_frame("t6b", CAM_H, 1'b0);
    check_eq("t6_count", m_frame_count, 1);

    check_eq("total_overrun", n_ovr, 1);
    check_eq("total_drop", n_drop, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
